// File: rtl/mm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mm_bus_arbiter
//
// Purpose:
//   Arbitrates the external memory-mapped peripheral bus between master 0
//   (CPU) and master 1 (DMA / debug port). Each access occupies the bus for
//   WAIT_CYC+1 cycles (XFER). It is followed by a single RESP cycle, in which
//   the granted master sees a one-cycle done pulse and, for a read, its
//   captured read data.
//   Total latency from the sampling edge to the done cycle is WAIT_CYC+2.
//
// Parameters:
//   WAIT_CYC  wait states per access (0..15); XFER lasts WAIT_CYC+1 cycles
//   DATA_W    data bus width
//   ADDR_W    address bus width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_re / mX_we            master X read / write request (both set = write)
//   mX_addr / mX_wdata       master X address / write data
//   mX_rdata                 master X read data, held until its next read
//   mX_done                  master X one-cycle access-complete pulse
//   mX_stall                 master X must hold its request stable
//   mm_re / mm_we            bus strobes, high for the whole XFER phase
//   mm_addr / mm_wdata       bus address / write data (latched at grant)
//   mm_rdata                 bus read data, sampled on the last XFER edge
//
// Configuration macro:
//   MM_CPU_PRIORITY_EN  defined   -> ties always go to master 0
//                       undefined -> round-robin tie-breaking (default)
// -----------------------------------------------------------------------------
module mm_bus_arbiter #(
  parameter int WAIT_CYC = 2,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_re,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_stall,
  input  logic              m1_re,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_stall,
  output logic              mm_re,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_gnt;   // master granted on the most recent tie
  logic   r_gnt;        // master owning the current access
  logic [3:0] r_cnt;    // remaining XFER cycles minus one

  logic              w_req0;
  logic              w_req1;
  logic              w_tie;
  logic              w_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_req0 = m0_re | m0_we;
  assign w_req1 = m1_re | m1_we;
  assign w_tie  = w_req0 & w_req1;

  // Winner selection for the IDLE cycle. With a single requester it simply
  // wins; only a tie consults the tie-breaking policy.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    w_gnt = w_req1 & ~w_req0;
    if (w_tie) begin
`ifdef MM_CPU_PRIORITY_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_last_gnt;
`endif
    end
  end

  // Request of the would-be winner; a write takes precedence over a read.
  assign w_sel_we    = w_gnt ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;

  // A master is released in the very cycle its done pulse is high.
  assign m0_stall = w_req0 & ~m0_done;
  assign m1_stall = w_req1 & ~m1_done;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_cnt      <= '0;
      mm_re      <= 1'b0;
      mm_we      <= 1'b0;
      mm_addr    <= '0;
      mm_wdata   <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
    end else begin
      // Done is a single-cycle pulse; only the XFER->RESP transition sets it.
      m0_done <= 1'b0;
      m1_done <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_req0 || w_req1) begin
            r_gnt    <= w_gnt;
            mm_addr  <= w_sel_addr;
            mm_wdata <= w_sel_wdata;
            mm_we    <= w_sel_we;
            mm_re    <= ~w_sel_we;
            // WAIT_CYC is limited to 0..15, so 4 bits always hold it.
            r_cnt    <= 4'(WAIT_CYC);
            r_state  <= ST_XFER;
            // Only ties move the round-robin pointer, so a lone requester
            // does not rob the other master of its next tie.
            if (w_tie) begin
              r_last_gnt <= w_gnt;
            end
          end
        end

        ST_XFER: begin
          if (r_cnt == 4'd0) begin
            // mm_we still reflects the access type on this last XFER edge.
            if (!mm_we) begin
              if (r_gnt) m1_rdata <= mm_rdata;
              else       m0_rdata <= mm_rdata;
            end
            if (r_gnt) m1_done <= 1'b1;
            else       m0_done <= 1'b1;
            mm_re    <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= '0;
            mm_wdata <= '0;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mm_bus_arbiter
//
// Self-checking bench for mm_bus_arbiter. The main instance runs with
// WAIT_CYC=2, a second instance with WAIT_CYC=0. Expected bus activity is
// derived from the access timeline: an access granted at the end of
// relative cycle s drives the bus in cycles s+1..s+1+W, pulses done in cycle
// s+2+W, and a waiting master is granted at the end of cycle s+3+W.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mm_bus_arbiter;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_re, m0_we, m1_re, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_stall, m1_stall;
  logic        mm_re, mm_we;
  logic [15:0] mm_addr, mm_wdata, mm_rdata;

  logic        z_m0_re, z_m0_we, z_m1_re, z_m1_we;
  logic [15:0] z_m0_addr, z_m0_wdata, z_m1_addr, z_m1_wdata;
  logic [15:0] z_m0_rdata, z_m1_rdata;
  logic        z_m0_done, z_m1_done, z_m0_stall, z_m1_stall;
  logic        z_mm_re, z_mm_we;
  logic [15:0] z_mm_addr, z_mm_wdata, z_mm_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: master that won the latest tie, and each master's
  // currently held read data.
  bit          model_last;
  logic [15:0] exp_rd [2];

  mm_bus_arbiter #(.WAIT_CYC(W), .DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_stall(m0_stall),
    .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_stall(m1_stall),
    .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata)
  );

  mm_bus_arbiter #(.WAIT_CYC(0), .DATA_W(16), .ADDR_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .m0_re(z_m0_re), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata),
    .m0_rdata(z_m0_rdata), .m0_done(z_m0_done), .m0_stall(z_m0_stall),
    .m1_re(z_m1_re), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata),
    .m1_rdata(z_m1_rdata), .m1_done(z_m1_done), .m1_stall(z_m1_stall),
    .mm_re(z_mm_re), .mm_we(z_mm_we), .mm_addr(z_mm_addr), .mm_wdata(z_mm_wdata),
    .mm_rdata(z_mm_rdata)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ty[0] = re, ty[1] = we
  task automatic drive_m(input int m, input bit on, input logic [1:0] ty,
                         input logic [15:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_re = on & ty[0]; m0_we = on & ty[1]; m0_addr = a; m0_wdata = d;
    end else begin
      m1_re = on & ty[0]; m1_we = on & ty[1]; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic test_reset();
    logic [69:0] got;
    rst = 1'b1;
    drive_m(0, 1'b0, 2'b00, 16'h0, 16'h0);
    drive_m(1, 1'b0, 2'b00, 16'h0, 16'h0);
    mm_rdata = 16'h0;
    z_m0_re = 0; z_m0_we = 0; z_m1_re = 0; z_m1_we = 0;
    z_m0_addr = 0; z_m0_wdata = 0; z_m1_addr = 0; z_m1_wdata = 0; z_mm_rdata = 0;
    step(); step();
    got = {mm_re, mm_we, mm_addr, mm_wdata, m0_rdata, m1_rdata, m0_done, m1_done,
           m0_stall, m1_stall};
    n_checks++;
    if (got !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    n_checks++;
    if ({z_mm_re, z_mm_we, z_m0_done, z_m1_done, z_m0_rdata} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_w0 got=%h exp=0",
               {z_mm_re, z_mm_we, z_m0_done, z_m1_done, z_m0_rdata});
    end
    rst = 1'b0;
    model_last = 1'b1;
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    step();
  endtask

  // One arbitration round: the selected masters raise requests together in
  // an IDLE cycle, hold them while stalled and drop them in their done cycle.
  task automatic run_txn(input string tag, input bit use0, input bit use1,
                         input logic [1:0] ty0, input logic [1:0] ty1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input bit rd_fix, input logic [15:0] rd_val);
    int          order [2];
    int          start [2];
    int          n;
    int          last_cyc;
    bit          req_now [2];
    logic [1:0]  ty [2];
    logic [15:0] addr [2];
    logic [15:0] wd [2];
    logic [15:0] rd_hist [32];
    logic [5:0]  got, exp;
    bit          e_re, e_we, act;
    bit          e_done [2];
    logic [15:0] e_addr, e_wd;

    ty[0] = ty0; ty[1] = ty1; addr[0] = a0; addr[1] = a1; wd[0] = d0; wd[1] = d1;
    start[0] = 0; start[1] = 0;
    if (use0 && use1) begin
      order[0] = model_last ? 0 : 1;
      order[1] = 1 - order[0];
      model_last = (order[0] == 1);
      n = 2;
    end else begin
      order[0] = use1 ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    start[order[0]] = 0;
    if (n == 2) start[order[1]] = W + 3;
    last_cyc = start[order[n-1]] + W + 2;

    req_now[0] = use0;
    req_now[1] = use1;
    drive_m(0, use0, ty0, a0, d0);
    drive_m(1, use1, ty1, a1, d1);
    rd_hist[0] = rd_fix ? rd_val : 16'($urandom);
    mm_rdata = rd_hist[0];

    for (int k = 1; k <= last_cyc; k++) begin
      step();
      e_re = 0; e_we = 0; act = 0; e_addr = 16'h0; e_wd = 16'h0;
      e_done[0] = 0; e_done[1] = 0;
      for (int j = 0; j < n; j++) begin
        int m;
        m = order[j];
        if (k >= start[m] + 1 && k <= start[m] + 1 + W) begin
          act = 1;
          if (ty[m][1]) e_we = 1; else e_re = 1;
          e_addr = addr[m];
          e_wd = wd[m];
        end
        if (k == start[m] + W + 2) begin
          e_done[m] = 1;
          if (!ty[m][1]) exp_rd[m] = rd_hist[start[m] + 1 + W];
        end
      end
      got = {mm_re, mm_we, m0_done, m1_done, m0_stall, m1_stall};
      exp = {e_re, e_we, e_done[0], e_done[1],
             req_now[0] & ~e_done[0], req_now[1] & ~e_done[1]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s ctrl cyc=%0d got re,we,d0,d1,s0,s1=%b exp=%b", tag, k, got, exp);
      end
      if (act) begin
        n_checks++;
        if (mm_addr !== e_addr) begin
          n_fail++;
          $display("FAIL %s mm_addr cyc=%0d got=%h exp=%h", tag, k, mm_addr, e_addr);
        end
        if (e_we) begin
          n_checks++;
          if (mm_wdata !== e_wd) begin
            n_fail++;
            $display("FAIL %s mm_wdata cyc=%0d got=%h exp=%h", tag, k, mm_wdata, e_wd);
          end
        end
      end
      if (e_done[0] || e_done[1]) begin
        n_checks++;
        if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin
          n_fail++;
          $display("FAIL %s rdata cyc=%0d got m0=%h m1=%h exp m0=%h m1=%h",
                   tag, k, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (e_done[m]) begin
          req_now[m] = 0;
          drive_m(m, 1'b0, 2'b00, 16'h0, 16'h0);
        end
      end
      rd_hist[k] = rd_fix ? rd_val : 16'($urandom);
      mm_rdata = rd_hist[k];
    end
    // Safety: release anything still asserted, then land in IDLE.
    drive_m(0, 1'b0, 2'b00, 16'h0, 16'h0);
    drive_m(1, 1'b0, 2'b00, 16'h0, 16'h0);
    step();
    n_checks++;
    if ({mm_re, mm_we, m0_done, m1_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle_after got=%b exp=0000", tag, {mm_re, mm_we, m0_done, m1_done});
    end
  endtask

  task automatic test_read_m0();
    run_txn("read_m0", 1, 0, 2'b01, 2'b00, 16'h2004, 16'h0, 16'h0, 16'h0, 1, 16'hBEEF);
    n_checks++;
    if (m0_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL read_m0_hold got=%h exp=BEEF", m0_rdata);
    end
  endtask

  task automatic test_write_m1();
    run_txn("write_m1", 0, 1, 2'b00, 2'b10, 16'h0, 16'hE000, 16'h0, 16'h1234, 0, 16'h0);
  endtask

  task automatic test_tie();
    run_txn("tie_a", 1, 1, 2'b01, 2'b01, 16'h3000, 16'h3002, 16'h0, 16'h0, 0, 16'h0);
    run_txn("tie_b", 1, 1, 2'b01, 2'b01, 16'h3004, 16'h3006, 16'h0, 16'h0, 0, 16'h0);
  endtask

  // Both masters keep requesting reads through four accesses.
  task automatic test_continuous();
    localparam int PER = W + 3;
    int          win [4];
    logic [15:0] rd_prev;
    logic [3:0]  got, exp;
    bit          d0, d1;
    int          j, r;
    for (int i = 0; i < 4; i++) begin
`ifdef MM_CPU_PRIORITY_EN
      win[i] = 0;
`else
      win[i] = model_last ? 0 : 1;
      model_last = (win[i] == 1);
`endif
    end
    drive_m(0, 1'b1, 2'b01, 16'h5000, 16'h0);
    drive_m(1, 1'b1, 2'b01, 16'h6000, 16'h0);
    rd_prev = 16'($urandom);
    mm_rdata = rd_prev;
    for (int k = 1; k <= 4 * PER - 1; k++) begin
      step();
      j = (k - 1) / PER;
      r = (k - 1) % PER;
      d0 = (r == W + 1) && (win[j] == 0);
      d1 = (r == W + 1) && (win[j] == 1);
      got = {m0_done, m1_done, m0_stall, m1_stall};
      exp = {d0, d1, ~d0, ~d1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL continuous ctrl cyc=%0d got d0,d1,s0,s1=%b exp=%b", k, got, exp);
      end
      if (r <= W) begin
        n_checks++;
        if ({mm_re, mm_addr} !== {1'b1, (win[j] == 0) ? 16'h5000 : 16'h6000}) begin
          n_fail++;
          $display("FAIL continuous bus cyc=%0d got re=%b addr=%h exp owner=m%0d",
                   k, mm_re, mm_addr, win[j]);
        end
      end
      if (d0 || d1) begin
        exp_rd[win[j]] = rd_prev;
        n_checks++;
        if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin
          n_fail++;
          $display("FAIL continuous rdata cyc=%0d got m0=%h m1=%h exp m0=%h m1=%h",
                   k, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
        end
      end
      rd_prev = 16'($urandom);
      mm_rdata = rd_prev;
    end
    drive_m(0, 1'b0, 2'b00, 16'h0, 16'h0);
    drive_m(1, 1'b0, 2'b00, 16'h0, 16'h0);
    step();
  endtask

  task automatic test_reset_mid_write();
    drive_m(0, 1'b1, 2'b10, 16'h2222, 16'hCAFE);
    step();
    n_checks++;
    if ({mm_we, mm_wdata} !== {1'b1, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL rst_mid xfer1 got we=%b wdata=%h exp we=1 wdata=cafe", mm_we, mm_wdata);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({mm_we, mm_re, m0_done, m0_stall, mm_addr} !== {4'b0001, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_mid abort got we,re,done,stall=%b addr=%h exp 0001 addr=0",
               {mm_we, mm_re, m0_done, m0_stall}, mm_addr);
    end
    rst = 1'b0;
    drive_m(0, 1'b0, 2'b00, 16'h0, 16'h0);
    model_last = 1'b1;
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({m0_done, mm_we, mm_re} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_mid no_done cyc=%0d got done,we,re=%b exp=000", k,
                 {m0_done, mm_we, mm_re});
      end
    end
  endtask

  task automatic test_wait0();
    z_m0_re = 1; z_m0_we = 1; z_m0_addr = 16'h4000; z_m0_wdata = 16'hA5A5;
    z_mm_rdata = 16'h7777;
    step();
    n_checks++;
    if ({z_mm_re, z_mm_we, z_m0_done, z_mm_addr, z_mm_wdata} !== {3'b010, 16'h4000, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL wait0_wr xfer got re,we,done=%b addr=%h wdata=%h",
               {z_mm_re, z_mm_we, z_m0_done}, z_mm_addr, z_mm_wdata);
    end
    step();
    n_checks++;
    if ({z_mm_re, z_mm_we, z_m0_done, z_m0_stall, z_m0_rdata} !== {4'b0010, 16'h0}) begin
      n_fail++;
      $display("FAIL wait0_wr done got re,we,done,stall=%b rdata=%h exp 0010 rdata=0",
               {z_mm_re, z_mm_we, z_m0_done, z_m0_stall}, z_m0_rdata);
    end
    z_m0_re = 0; z_m0_we = 0;
    step();
    z_m0_re = 1; z_m0_addr = 16'h4002; z_mm_rdata = 16'h5A5A;
    step();
    n_checks++;
    if ({z_mm_re, z_mm_we, z_m0_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL wait0_rd xfer got re,we,done=%b exp=100", {z_mm_re, z_mm_we, z_m0_done});
    end
    z_mm_rdata = 16'h5A5B;
    step();
    n_checks++;
    if ({z_m0_done, z_mm_re, z_m0_rdata} !== {2'b10, 16'h5A5B}) begin
      n_fail++;
      $display("FAIL wait0_rd done got done,re=%b rdata=%h exp 10 rdata=5a5b",
               {z_m0_done, z_mm_re}, z_m0_rdata);
    end
    z_m0_re = 0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int         s;
      logic [1:0] t0, t1;
      logic [15:0] a0, a1;
      s  = $urandom_range(1, 3);
      t0 = 2'($urandom_range(1, 3));
      t1 = 2'($urandom_range(1, 3));
      a0 = {3'($urandom_range(1, 7)), 13'($urandom)};
      a1 = {3'($urandom_range(1, 7)), 13'($urandom)};
      run_txn("random", (s & 1) != 0, (s & 2) != 0, t0, t1, a0, a1,
              16'($urandom), 16'($urandom), 0, 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_wait0();
    test_read_m0();
    test_write_m1();
    test_tie();
    test_continuous();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_bus_arbiter.md
Name: mm_bus_arbiter

Overview:
- Arbitrates the external memory-mapped bus (addresses with addr[15:13] != 0) between two masters: the CPU (master 0) and an auxiliary master such as a DMA or debug port (master 1).
- Sequences each access with a programmable number of wait states.
- Stalls the waiting or in-flight master and returns read data with a one-cycle done pulse.
- Sits between the CPU's mm_re/mm_we/addr/wdata/rdata port and the external peripheral bus.

Parameters:
WAIT_CYC, 2, wait states per access; the bus phase lasts WAIT_CYC+1 cycles (legal range 0..15)
DATA_W, 16, data bus width
ADDR_W, 16, address bus width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_re  in  1  master 0 read request
- m0_we  in  1  master 0 write request
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data; valid while m0_done=1
- m0_done  out  1  master 0 access-complete pulse
- m0_stall  out  1  master 0 must hold its request stable
- m1_re, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_stall: same as master 0, for master 1
- mm_re  out  1  bus read strobe
- mm_we  out  1  bus write strobe
- mm_addr  out  ADDR_W  bus address
- mm_wdata  out  DATA_W  bus write data
- mm_rdata  in  DATA_W  bus read data

Behaviour:
- Clock and reset: single clock. All state changes on the rising edge of clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE, last_gnt = 1 (so master 0 wins the first tie), wait counter = 0.
  - All outputs 0: mm_re, mm_we, mm_addr, mm_wdata, m*_rdata, m*_done.
- Request definitions:
  - req_i = mi_re | mi_we.
  - If both re and we are set on the same master, the access is a write; re is ignored.
- FSM states:
  - IDLE:
    - If any req_i is set: grant, latch that master's addr, wdata and type, load cnt = WAIT_CYC, go to XFER.
    - Tie (both requesting): grant the master that is not last_gnt, then set last_gnt = granted master.
  - XFER:
    - mm_addr and mm_wdata drive the latched values; mm_re or mm_we = 1 for exactly WAIT_CYC+1 cycles; cnt decrements.
    - When cnt = 0: on a read, capture mm_rdata into the granted mi_rdata; go to RESP.
  - RESP:
    - Strobes return to 0; granted mi_done = 1 for exactly one cycle; go to IDLE.
- Stall:
  - mi_stall = req_i & ~mi_done (combinational).
  - A master is released in the same cycle its done pulse is high.
- Latency:
  - Request sampled at edge t, XFER cycles t+1 .. t+1+WAIT_CYC, done at cycle t+2+WAIT_CYC.
  - Total latency = WAIT_CYC+2 cycles.
  - No back-to-back bus cycles: a minimum of one idle cycle (RESP) separates accesses.
- Request withdrawal: a master that drops its request during XFER does not abort the access; the access completes and the done pulse is still issued.
- Read data hold: mi_rdata holds its captured value until that master's next read completes. Writes leave mi_rdata unchanged.
- Losing master: stall stays high through the winner's access. The loser is granted in the IDLE cycle after the winner's RESP; round-robin guarantees no starvation.
- Reset during XFER or RESP: the access is aborted, no done pulse is issued, and all outputs return to reset values on that edge.
- WAIT_CYC = 0: XFER lasts exactly one cycle.

Optional Feature:
- Macro: MM_CPU_PRIORITY_EN.
- Defined:
  - Ties in IDLE always go to master 0 (fixed priority). last_gnt is ignored.
  - Master 1 may starve under continuous CPU traffic; this is intended for real-time CPU paths.
- Undefined: round-robin tie-breaking as above (default).

Test Plan:
- Reset, then m0_re=1, m0_addr=16'h2004, mm_rdata=16'hBEEF, WAIT_CYC=2:
  - mm_re high for 3 cycles with mm_addr=16'h2004.
  - m0_done pulses 4 cycles after the request; m0_rdata=16'hBEEF; m0_stall low on the done cycle.
- m1_we=1, m1_addr=16'hE000, m1_wdata=16'h1234:
  - mm_we=1, mm_wdata=16'h1234 for 3 cycles.
  - m1_done pulses; m1_rdata unchanged.
- m0_re and m1_re asserted in the same cycle after reset:
  - m0 served first, then m1 served in the IDLE cycle following m0's RESP.
  - Repeating the tie then serves m1 first.
- With MM_CPU_PRIORITY_EN defined, both masters request continuously:
  - m0 granted every access; m1_stall stays high.
- rst pulsed on the second XFER cycle of a write:
  - mm_we=0 and m0_done=0 on the next edge; FSM in IDLE; no done pulse is ever issued for that write.
- WAIT_CYC=0 with m0_re=1 and m0_we=1 together:
  - Treated as a write; mm_we high for 1 cycle, mm_re stays 0; m0_done at t+2.
